// File: rtl/term_pkg.sv
// term_pkg: shared constants, FSM state type and byte classification for term_writer
package term_pkg;
  localparam int COLS_LOG2_DEF = 6;
  localparam int ROWS_LOG2_DEF = 5;
  localparam logic [7:0] BLANK_DEF = 8'h20;
  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_DEL = 8'h7F;
  typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_SCREEN} state_t;
  function automatic logic is_printable(input logic [7:0] b);
    return b >= 8'h20 && b != CC_DEL;
  endfunction
endpackage

// File: rtl/term_writer_if.sv
// term_writer_if: received-byte valid/ready stream into term_writer
interface term_writer_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/term_writer.sv
// term_writer: turns terminal bytes into VRAM writes, cursor moves and hardware scrolling
module term_writer
  import term_pkg::*;
#(
  parameter int COLS_LOG2 = COLS_LOG2_DEF,
  parameter int ROWS_LOG2 = ROWS_LOG2_DEF,
  parameter logic [7:0] BLANK = BLANK_DEF
) (
  input  logic clk,
  input  logic reset,
  term_writer_if.slave rx,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] vram_ad,
  output logic [7:0] vram_din,
  output logic vram_we,
  output logic [COLS_LOG2-1:0] cursor_col,
  output logic [ROWS_LOG2-1:0] cursor_row,
  output logic [ROWS_LOG2-1:0] scroll_row
);
  localparam int AW = COLS_LOG2 + ROWS_LOG2;
  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n, ad_n;
  logic [COLS_LOG2-1:0] col_n;
  logic [ROWS_LOG2-1:0] row_n, scroll_n;
  logic [7:0] din_n, b;
  logic we_n, pend, pend_n, accept, last_col, last_row, advance;
  assign rx.ready = state == IDLE && !reset;
  assign b = rx.data;
  assign accept = rx.valid && rx.ready;
  assign last_col = &cursor_col;
  assign last_row = &cursor_row;
  assign advance = accept && (b == CC_LF || (is_printable(b) && last_col));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    col_n = cursor_col;
    row_n = cursor_row;
    scroll_n = scroll_row;
    pend_n = pend;
    we_n = 1'b0;
    ad_n = vram_ad;
    din_n = vram_din;
    if (advance) begin
      row_n = last_row ? cursor_row : cursor_row + 1'b1;
      scroll_n = last_row ? scroll_row + 1'b1 : scroll_row;
    end
    case (state)
      IDLE: if (accept) begin
        if (is_printable(b)) begin
          state_n = PUT;
          we_n = 1'b1;
          ad_n = {cursor_row + scroll_row, cursor_col};
          din_n = b;
          col_n = cursor_col + 1'b1;
          pend_n = last_col && last_row;
        end else if (b == CC_CR) col_n = '0;
        else if (b == CC_BS) col_n = cursor_col - COLS_LOG2'(cursor_col != '0);
        else if (b == CC_FF) begin
          state_n = CLR_SCREEN;
          we_n = 1'b1;
          ad_n = '0;
          din_n = BLANK;
          cnt_n = AW'(1);
        end else if (b == CC_LF && last_row) begin
          // the row being vacated at the top becomes the new bottom line
          state_n = CLR_LINE;
          we_n = 1'b1;
          ad_n = {scroll_row, COLS_LOG2'(0)};
          din_n = BLANK;
          cnt_n = AW'(1);
        end
      end
      PUT: if (pend) begin
        state_n = CLR_LINE;
        we_n = 1'b1;
        ad_n = {scroll_row - 1'b1, COLS_LOG2'(0)};
        din_n = BLANK;
        cnt_n = AW'(1);
        pend_n = 1'b0;
      end else state_n = IDLE;
      CLR_LINE: if (cnt[COLS_LOG2-1:0] == '0) state_n = IDLE;
      else begin
        we_n = 1'b1;
        ad_n = {scroll_row - 1'b1, cnt[COLS_LOG2-1:0]};
        din_n = BLANK;
        cnt_n = cnt + 1'b1;
      end
      CLR_SCREEN: if (cnt == '0) begin
        state_n = IDLE;
        col_n = '0;
        row_n = '0;
        scroll_n = '0;
      end else begin
        we_n = 1'b1;
        ad_n = cnt;
        din_n = BLANK;
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend <= 1'b0;
      cursor_col <= '0;
      cursor_row <= '0;
      scroll_row <= '0;
      vram_we <= 1'b0;
      vram_ad <= '0;
      vram_din <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend <= pend_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
      scroll_row <= scroll_n;
      vram_we <= we_n;
      vram_ad <= ad_n;
      vram_din <= din_n;
    end
  end
endmodule

// File: tb/tb_term_writer.sv
// tb_term_writer: directed stimulus with a write scoreboard for term_writer
module tb_term_writer;
  import term_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] vram_ad;
  logic [7:0] vram_din;
  logic vram_we;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row, scroll_row;
  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp_w;
  logic [7:0] seq [5] = '{CC_BS, CC_BS, CC_CR, 8'h07, CC_DEL};
  int seq_col [5] = '{4, 3, 0, 0, 0};
  logic [7:0] chars [64];
  term_writer_if rx();
  term_writer dut (
    .clk(clk), .reset(reset), .rx(rx),
    .vram_ad(vram_ad), .vram_din(vram_din), .vram_we(vram_we),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .scroll_row(scroll_row)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (vram_we === 1'b1) begin
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected write: ad=%0d din=%0h, want no write", vram_ad, vram_din);
    end else begin
      exp_w = exp_q.pop_front();
      check("vram write {ad,din}", {vram_ad, vram_din}, exp_w);
    end
  end
  task automatic push(input int ad, input logic [7:0] d);
    exp_q.push_back({ad[10:0], d});
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (rx.ready !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_ready timeout: got 0, want 1");
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n;
    rx.data = b;
    rx.valid = 1'b1;
    wait_ready(n);
    @(posedge clk);
    #1;
    rx.valid = 1'b0;
  endtask
  task automatic check_cursor(input string name, input int c, input int r, input int s);
    check({name, " col"}, cursor_col, c);
    check({name, " row"}, cursor_row, r);
    check({name, " scroll"}, scroll_row, s);
  endtask
  initial begin
    int n;
    rx.valid = 1'b0;
    rx.data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_ready", rx.ready, 0);
    check("reset vram_we", vram_we, 0);
    check("reset vram_ad", vram_ad, 0);
    check("reset vram_din", vram_din, 0);
    check_cursor("reset", 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready after reset", rx.ready, 1);
    push(0, 8'h41);
    send(8'h41);
    wait_ready(n);
    check("printable busy cycles", n, 1);
    check_cursor("after A", 1, 0, 0);
    send(CC_CR);
    for (int i = 0; i < 64; i++) begin
      chars[i] = i == 0 ? 8'h20 : i == 63 ? 8'hFF : 8'(8'h40 + i);
      push(i, chars[i]);
    end
    for (int i = 0; i < 64; i++) send(chars[i]);
    wait_ready(n);
    check_cursor("64 chars", 0, 1, 0);
    repeat (30) send(CC_LF);
    check_cursor("30 LF", 0, 31, 0);
    for (int c = 0; c < 64; c++) push(c, BLANK_DEF);
    send(CC_LF);
    wait_ready(n);
    check("LF scroll busy cycles", n, 64);
    check_cursor("LF scroll", 0, 31, 1);
    push(0, 8'h5A);
    for (int i = 1; i < 5; i++) push(i, 8'(8'h60 + i));
    send(8'h5A);
    for (int i = 1; i < 5; i++) send(8'(8'h60 + i));
    wait_ready(n);
    check_cursor("post-scroll chars", 5, 31, 1);
    rx.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx.data = seq[i];
      check("ctrl rx_ready", rx.ready, 1);
      @(posedge clk);
      #1;
      check("ctrl col", cursor_col, seq_col[i]);
    end
    rx.valid = 1'b0;
    check_cursor("ctrl end", 0, 31, 1);
    for (int i = 0; i < 64; i++) begin
      chars[i] = 8'(8'h61 + i % 26);
      push(i, chars[i]);
    end
    for (int c = 0; c < 64; c++) push(64 + c, BLANK_DEF);
    for (int i = 0; i < 64; i++) send(chars[i]);
    wait_ready(n);
    check("autowrap busy cycles", n, 65);
    check_cursor("autowrap", 0, 31, 2);
    for (int s = 2; s < 7; s++) begin
      for (int c = 0; c < 64; c++) push(s * 64 + c, BLANK_DEF);
      send(CC_LF);
      wait_ready(n);
    end
    check_cursor("scroll to 7", 0, 31, 7);
    for (int a = 0; a < 2048; a++) push(a, BLANK_DEF);
    send(CC_FF);
    wait_ready(n);
    check("FF busy cycles", n, 2048);
    check_cursor("FF", 0, 0, 0);
    repeat (31) send(CC_LF);
    check_cursor("31 LF", 0, 31, 0);
    for (int c = 0; c < 10; c++) push(c, BLANK_DEF);
    send(CC_LF);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort vram_we", vram_we, 0);
    check("abort vram_ad", vram_ad, 0);
    check("abort vram_din", vram_din, 0);
    check("abort rx_ready", rx.ready, 0);
    check_cursor("abort", 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready after abort", rx.ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check("writes outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
